// File: rtl/pixel_plot_arbiter.sv
// rtl/pixel_plot_arbiter.sv - round-robin owner of the vga_adapter plot port with optional screen clear.
// Define PLOT_ARB_CLEAR_ENGINE_EN to build in the full-screen clear sweep.
module pixel_plot_arbiter #(
   parameter int NREQ = 5,
   parameter int XMAX = 160,
   parameter int YMAX = 120
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic [NREQ-1:0]     req,
   input  logic [18*NREQ-1:0]  req_xyc,
   output logic [NREQ-1:0]     gnt,
   input  logic                clear_start,
   input  logic [2:0]          clear_colour,
   output logic                clear_busy,
   output logic                clear_done,
   output logic [7:0]          x,
   output logic [6:0]          y,
   output logic [2:0]          colour,
   output logic                plot,
   output logic [7:0]          drop_cnt
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [8:0] XLIM = 9'(XMAX);
   localparam logic [7:0] YLIM = 8'(YMAX);

   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [7:0]      x_q, x_d;
   logic [6:0]      y_q, y_d;
   logic [2:0]      colour_q, colour_d;
   logic            plot_q, plot_d;
   logic [7:0]      drop_q, drop_d;

   logic [NREQ-1:0] elig;
   logic [PW-1:0]   cand [NREQ];
   logic [17:0]     slot [NREQ];
   logic            arb_hit;
   logic [PW-1:0]   arb_idx;
   logic [17:0]     arb_xyc;
   logic            arb_oor;
   logic            run_arb;

`ifdef PLOT_ARB_CLEAR_ENGINE_EN
   localparam logic [7:0] XLAST = 8'(XMAX - 1);
   localparam logic [6:0] YLAST = 7'(YMAX - 1);

   typedef enum logic {ARB, CLEAR} state_e;
   state_e      state_q, state_d;
   logic [7:0]  cx_q, cx_d;
   logic [6:0]  cy_q, cy_d;
   logic [2:0]  ccol_q, ccol_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
`else
   logic unused_clear;
   assign unused_clear = ^{clear_start, clear_colour};
`endif

   // A requester whose grant is showing this cycle is masked so it cannot be granted twice.
   always_comb begin
      elig    = req & ~gnt_q;
      arb_hit = 1'b0;
      arb_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand[k] = PW'((int'(ptr_q) + k) % NREQ);
         slot[k] = req_xyc[18*k +: 18];
      end
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (elig[cand[k]]) begin
            arb_hit = 1'b1;
            arb_idx = cand[k];
         end
      end
      arb_xyc = slot[arb_idx];
      arb_oor = ({1'b0, arb_xyc[17:10]} >= XLIM) || ({1'b0, arb_xyc[9:3]} >= YLIM);
   end

   always_comb begin
      gnt_d    = '0;
      ptr_d    = ptr_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      plot_d   = 1'b0;
      drop_d   = drop_q;
`ifdef PLOT_ARB_CLEAR_ENGINE_EN
      state_d  = state_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      ccol_d   = ccol_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      run_arb  = 1'b0;
      case (state_q)
         ARB: begin
            if (clear_start) begin
               state_d  = CLEAR;
               cx_d     = '0;
               cy_d     = '0;
               ccol_d   = clear_colour;
               x_d      = '0;
               y_d      = '0;
               colour_d = clear_colour;
               plot_d   = 1'b1;
               busy_d   = 1'b1;
            end else begin
               run_arb = 1'b1;
            end
         end
         CLEAR: begin
            if (cx_q == XLAST && cy_q == YLAST) begin
               state_d = ARB;
               done_d  = 1'b1;
               run_arb = 1'b1;
            end else begin
               if (cx_q == XLAST) begin
                  cx_d = '0;
                  cy_d = cy_q + 1'b1;
               end else begin
                  cx_d = cx_q + 1'b1;
               end
               x_d      = cx_d;
               y_d      = cy_d;
               colour_d = ccol_q;
               plot_d   = 1'b1;
               busy_d   = 1'b1;
            end
         end
         default: state_d = ARB;
      endcase
`else
      run_arb  = 1'b1;
`endif
      if (run_arb && arb_hit) begin
         gnt_d[arb_idx] = 1'b1;
         ptr_d = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
         if (arb_oor) begin
            if (drop_q != 8'hFF)
               drop_d = drop_q + 1'b1;
         end else begin
            x_d      = arb_xyc[17:10];
            y_d      = arb_xyc[9:3];
            colour_d = arb_xyc[2:0];
            plot_d   = 1'b1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         gnt_q    <= '0;
         ptr_q    <= '0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
         drop_q   <= '0;
`ifdef PLOT_ARB_CLEAR_ENGINE_EN
         state_q  <= ARB;
         cx_q     <= '0;
         cy_q     <= '0;
         ccol_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`endif
      end else begin
         gnt_q    <= gnt_d;
         ptr_q    <= ptr_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
         drop_q   <= drop_d;
`ifdef PLOT_ARB_CLEAR_ENGINE_EN
         state_q  <= state_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         ccol_q   <= ccol_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`endif
      end
   end

   assign gnt      = gnt_q;
   assign x        = x_q;
   assign y        = y_q;
   assign colour   = colour_q;
   assign plot     = plot_q;
   assign drop_cnt = drop_q;
`ifdef PLOT_ARB_CLEAR_ENGINE_EN
   assign clear_busy = busy_q;
   assign clear_done = done_q;
`else
   assign clear_busy = 1'b0;
   assign clear_done = 1'b0;
`endif

endmodule
